// File: rtl/mp_cache_l2_pkg.sv
// Shared L2 tag-array definitions: geometry, tag entry layout and controller state encoding.
package mp_cache_l2_pkg;

  localparam int unsigned L2_SETS    = 16;
  localparam int unsigned L2_IDX_W   = 4;
  localparam int unsigned L2_ENTRY_W = 24;

  typedef struct packed {
    logic        valid;
    logic        dirty;
    logic [21:0] tag;
  } tag_entry_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/mp_cache_l2_rr_arb2.sv
// Two-way round-robin arbiter between fill and invalidate writers; combinational grant.
module mp_cache_l2_rr_arb2
  import mp_cache_l2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_fill,
  input  logic i_req_inv,
  output logic o_gnt_fill,
  output logic o_gnt_inv
);

  logic r_last_inv;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    o_gnt_fill = 1'b0;
    o_gnt_inv  = 1'b0;
    if (i_en) begin
      if (i_req_fill && (!i_req_inv || r_last_inv)) begin
        o_gnt_fill = 1'b1;
      end else if (i_req_inv) begin
        o_gnt_inv = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_inv <= 1'b1;
    end else if (o_gnt_fill) begin
      r_last_inv <= 1'b0;
    end else if (o_gnt_inv) begin
      r_last_inv <= 1'b1;
    end
  end

endmodule

// File: rtl/mp_cache_l2_tag_ctrl.sv
// L2 tag SRAM controller: init/flush sweeps and arbitrated writes on port0, lookups with write bypass on port1.
module mp_cache_l2_tag_ctrl
  import mp_cache_l2_pkg::*;
#(
  parameter int unsigned SETS    = L2_SETS,
  parameter int unsigned IDX_W   = L2_IDX_W,
  parameter int unsigned ENTRY_W = L2_ENTRY_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lkp_valid,
  input  logic [IDX_W-1:0]   lkp_idx,
  output logic               lkp_ready,
  output logic               lkp_rvalid,
  output logic [ENTRY_W-1:0] lkp_rdata,
  input  logic               fill_valid,
  input  logic [IDX_W-1:0]   fill_idx,
  input  logic [ENTRY_W-1:0] fill_data,
  output logic               fill_ready,
  input  logic               inv_valid,
  input  logic [IDX_W-1:0]   inv_idx,
  output logic               inv_ready,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               flush_done,
  output logic               init_done,
  output logic               sram_csb0,
  output logic               sram_web0,
  output logic [IDX_W-1:0]   sram_addr0,
  output logic [ENTRY_W-1:0] sram_din0,
  output logic               sram_csb1,
  output logic [IDX_W-1:0]   sram_addr1,
  input  logic [ENTRY_W-1:0] sram_dout1
);

  state_e             r_state;
  logic [IDX_W-1:0]   r_cnt;
  logic               r_flush_done;
  logic               r_init_done;
  logic               r_flush_busy;
  logic               r_rvalid;
  logic               r_byp_hit;
  logic [ENTRY_W-1:0] r_byp_data;

  logic               w_run;
  logic               w_sweep;
  logic               w_last;
  logic               w_flush_go;
  logic               w_arb_en;
  logic               w_lkp_acc;
  logic               w_gnt_fill;
  logic               w_gnt_inv;
  logic               w_wr_en;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [ENTRY_W-1:0] w_wr_data;
  tag_entry_t         w_inv_entry;

  assign w_inv_entry = '{valid: 1'b0, dirty: 1'b0, tag: '0};

  // All SRAM strobes and readies are held idle while rst is asserted, whatever the state.
  assign w_run      = !rst && (r_state == RUN);
  assign w_sweep    = !rst && (r_state != RUN);
  assign w_last     = (r_cnt == IDX_W'(SETS - 1));
  // The flush_done cycle still sees flush_req high; it must not start a second sweep.
  assign w_flush_go = w_run && flush_req && !r_flush_done;
  assign w_arb_en   = w_run && !w_flush_go;
  assign w_lkp_acc  = w_run && lkp_valid;

  mp_cache_l2_rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_arb_en),
    .i_req_fill (fill_valid),
    .i_req_inv  (inv_valid),
    .o_gnt_fill (w_gnt_fill),
    .o_gnt_inv  (w_gnt_inv)
  );

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = '0;
    w_wr_data = '0;
    if (w_sweep) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = r_cnt;
      w_wr_data = ENTRY_W'(w_inv_entry);
    end else if (w_gnt_fill) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = fill_idx;
      w_wr_data = fill_data;
    end else if (w_gnt_inv) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = inv_idx;
      w_wr_data = ENTRY_W'(w_inv_entry);
    end
  end

  assign sram_csb0  = !w_wr_en;
  assign sram_web0  = !w_wr_en;
  assign sram_addr0 = w_wr_idx;
  assign sram_din0  = w_wr_data;
  assign sram_csb1  = !w_lkp_acc;
  assign sram_addr1 = w_lkp_acc ? lkp_idx : '0;

  assign fill_ready = w_gnt_fill;
  assign inv_ready  = w_gnt_inv;
  assign lkp_ready  = w_run;
  assign lkp_rvalid = r_rvalid;
  assign lkp_rdata  = r_byp_hit ? r_byp_data : sram_dout1;
  assign flush_busy = r_flush_busy;
  assign flush_done = r_flush_done;
  assign init_done  = r_init_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= INIT;
      r_cnt        <= '0;
      r_flush_done <= 1'b0;
      r_init_done  <= 1'b0;
      r_flush_busy <= 1'b1;
      r_rvalid     <= 1'b0;
      r_byp_hit    <= 1'b0;
      r_byp_data   <= '0;
    end else begin
      r_flush_done <= 1'b0;
      r_rvalid     <= w_lkp_acc;
      // The SRAM commits this write one edge too late for a same-cycle lookup to see it.
      r_byp_hit    <= w_lkp_acc && w_wr_en && (w_wr_idx == lkp_idx);
      r_byp_data   <= w_wr_data;
      unique case (r_state)
        INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state      <= RUN;
            r_cnt        <= '0;
            r_init_done  <= 1'b1;
            r_flush_busy <= 1'b0;
          end
        end
        RUN: begin
          if (w_flush_go) begin
            r_state      <= FLUSH;
            r_cnt        <= '0;
            r_flush_busy <= 1'b1;
          end
        end
        FLUSH: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state      <= RUN;
            r_cnt        <= '0;
            r_flush_busy <= 1'b0;
            r_flush_done <= 1'b1;
          end
        end
        default: begin
          r_state <= INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_cache_l2_tag_ctrl.sv
// Self-checking bench for mp_cache_l2_tag_ctrl with a behavioural dual-port tag SRAM and a lookup scoreboard.
module tb_mp_cache_l2_tag_ctrl;

  localparam int unsigned SETS    = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned ENTRY_W = 24;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               lkp_valid, lkp_ready, lkp_rvalid;
  logic [IDX_W-1:0]   lkp_idx;
  logic [ENTRY_W-1:0] lkp_rdata;
  logic               fill_valid, fill_ready;
  logic [IDX_W-1:0]   fill_idx;
  logic [ENTRY_W-1:0] fill_data;
  logic               inv_valid, inv_ready;
  logic [IDX_W-1:0]   inv_idx;
  logic               flush_req, flush_busy, flush_done, init_done;
  logic               sram_csb0, sram_web0, sram_csb1;
  logic [IDX_W-1:0]   sram_addr0, sram_addr1;
  logic [ENTRY_W-1:0] sram_din0, sram_dout1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [ENTRY_W-1:0] data;
    int                 rcyc;
  } exp_t;
  exp_t               sbq[$];
  exp_t               e;
  logic [ENTRY_W-1:0] model[SETS];

  mp_cache_l2_tag_ctrl #(.SETS(SETS), .IDX_W(IDX_W), .ENTRY_W(ENTRY_W)) dut (
    .clk(clk), .rst(rst),
    .lkp_valid(lkp_valid), .lkp_idx(lkp_idx), .lkp_ready(lkp_ready),
    .lkp_rvalid(lkp_rvalid), .lkp_rdata(lkp_rdata),
    .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data), .fill_ready(fill_ready),
    .inv_valid(inv_valid), .inv_idx(inv_idx), .inv_ready(inv_ready),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done), .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // Tag SRAM: registered address/controls, write commits one edge after registration, async read.
  logic [ENTRY_W-1:0] mem[SETS];
  logic               p_we;
  logic [IDX_W-1:0]   p_addr, r_a1;
  logic [ENTRY_W-1:0] p_din;

  initial begin
    for (int i = 0; i < SETS; i++) mem[i] = ENTRY_W'($urandom) | 24'h800000;
    p_we = 1'b0; p_addr = '0; p_din = '0; r_a1 = '0;
  end

  always @(posedge clk) begin
    if (p_we) mem[p_addr] <= p_din;
    p_we   <= !sram_csb0 && !sram_web0;
    p_addr <= sram_addr0;
    p_din  <= sram_din0;
    if (!sram_csb1) r_a1 <= sram_addr1;
  end
  assign sram_dout1 = mem[r_a1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].rcyc == cyc) begin
      e = sbq.pop_front();
      total++;
      if (lkp_rvalid !== 1'b1 || lkp_rdata !== e.data) begin
        bad++;
        $display("FAIL lookup cyc=%0d got rvalid=%b rdata=%h want rvalid=1 rdata=%h",
                 cyc, lkp_rvalid, lkp_rdata, e.data);
      end
    end else if (lkp_rvalid !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL unexpected_rvalid cyc=%0d got rvalid=%b want 0", cyc, lkp_rvalid);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    lkp_valid = 1'b0; lkp_idx = '0;
    fill_valid = 1'b0; fill_idx = '0; fill_data = '0;
    inv_valid = 1'b0; inv_idx = '0;
  endtask

  task automatic push_lkp(input logic [IDX_W-1:0] idx, input logic [ENTRY_W-1:0] d);
    lkp_valid = 1'b1;
    lkp_idx   = idx;
    sbq.push_back('{data: d, rcyc: cyc + 1});
  endtask

  task automatic test_reset();
    clr(); flush_req = 1'b0; rst = 1'b1;
    fill_valid = 1'b1; inv_valid = 1'b1; lkp_valid = 1'b1;
    step(); step(); #1;
    total++;
    if ({fill_ready, inv_ready, lkp_ready, sram_csb0, sram_web0, sram_csb1,
         flush_busy, init_done, flush_done, lkp_rvalid} !== 10'b000_111_1000) begin
      bad++;
      $display("FAIL reset_ctrl got %b want 0001111000", {fill_ready, inv_ready, lkp_ready,
               sram_csb0, sram_web0, sram_csb1, flush_busy, init_done, flush_done, lkp_rvalid});
    end
    total++;
    if ({sram_addr0, sram_din0, sram_addr1} !== '0) begin
      bad++;
      $display("FAIL reset_addr got a0=%h d0=%h a1=%h want 0", sram_addr0, sram_din0, sram_addr1);
    end
    step();
    rst = 1'b0; lkp_valid = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      #1;
      total++;
      if ({sram_csb0, sram_web0} !== 2'b00 || sram_addr0 !== IDX_W'(i) || sram_din0 !== '0 ||
          {fill_ready, inv_ready, lkp_ready} !== 3'b000 || init_done !== 1'b0 || flush_busy !== 1'b1) begin
        bad++;
        $display("FAIL init_sweep i=%0d got cs=%b we=%b a=%0d d=%h rdy=%b%b%b idone=%b busy=%b want 0 0 %0d 0 000 0 1",
                 i, sram_csb0, sram_web0, sram_addr0, sram_din0, fill_ready, inv_ready, lkp_ready,
                 init_done, flush_busy, i);
      end
      if (i == SETS - 1) clr();
      step();
    end
    #1;
    total++;
    if (init_done !== 1'b1 || flush_busy !== 1'b0 || sram_csb0 !== 1'b1 || lkp_ready !== 1'b1) begin
      bad++;
      $display("FAIL init_end got idone=%b busy=%b cs0=%b lrdy=%b want 1 0 1 1",
               init_done, flush_busy, sram_csb0, lkp_ready);
    end
    for (int i = 0; i < SETS; i++) model[i] = '0;
  endtask

  task automatic test_fill_lookup();
    clr(); fill_valid = 1'b1; fill_idx = 4'd3; fill_data = 24'hC00ABC; #1;
    total++;
    if (fill_ready !== 1'b1 || {sram_csb0, sram_web0} !== 2'b00 || sram_addr0 !== 4'd3 || sram_din0 !== 24'hC00ABC) begin
      bad++;
      $display("FAIL fill_write got rdy=%b cs=%b we=%b a=%0d d=%h want 1 0 0 3 c00abc",
               fill_ready, sram_csb0, sram_web0, sram_addr0, sram_din0);
    end
    model[3] = 24'hC00ABC;
    step(); clr(); step();
    push_lkp(4'd3, model[3]); #1;
    total++;
    if (lkp_ready !== 1'b1 || sram_csb1 !== 1'b0 || sram_addr1 !== 4'd3) begin
      bad++;
      $display("FAIL lkp_issue got rdy=%b cs1=%b a1=%0d want 1 0 3", lkp_ready, sram_csb1, sram_addr1);
    end
    step(); clr(); step(); step();
  endtask

  task automatic test_bypass();
    clr(); fill_valid = 1'b1; fill_idx = 4'd5; fill_data = 24'h400077; model[5] = 24'h400077;
    step(); clr(); step(); step();
    push_lkp(4'd5, model[5]);
    step();
    fill_valid = 1'b1; fill_idx = 4'd5; fill_data = 24'h801234; model[5] = 24'h801234;
    push_lkp(4'd5, model[5]);
    step();
    fill_valid = 1'b1; fill_idx = 4'd6; fill_data = 24'h123456; model[6] = 24'h123456;
    push_lkp(4'd5, model[5]);
    step(); clr(); step(); step();
  endtask

  task automatic test_arbitration();
    logic exp_fill;
    clr();
    for (int k = 0; k < 3; k++) begin
      fill_valid = 1'b1; fill_idx = 4'd9; fill_data = 24'hC00900 + ENTRY_W'(k); #1;
      total++;
      if (fill_ready !== 1'b1 || inv_ready !== 1'b0) begin
        bad++;
        $display("FAIL fill_only k=%0d got f=%b i=%b want 1 0", k, fill_ready, inv_ready);
      end
      step();
    end
    model[9] = 24'hC00902;
    clr();
    for (int k = 0; k < 2; k++) begin
      inv_valid = 1'b1; inv_idx = 4'd3; #1;
      total++;
      if (inv_ready !== 1'b1 || fill_ready !== 1'b0 || sram_din0 !== '0 || sram_addr0 !== 4'd3) begin
        bad++;
        $display("FAIL inv_only k=%0d got i=%b f=%b a=%0d d=%h want 1 0 3 0",
                 k, inv_ready, fill_ready, sram_addr0, sram_din0);
      end
      step();
    end
    model[3] = '0;
    clr();
    for (int k = 0; k < 4; k++) begin
      exp_fill = (k % 2 == 0);
      fill_valid = 1'b1; fill_idx = 4'd8; fill_data = 24'h800100 + ENTRY_W'(k);
      inv_valid = 1'b1; inv_idx = 4'd9; #1;
      total++;
      if (fill_ready !== exp_fill || inv_ready !== !exp_fill ||
          sram_addr0 !== (exp_fill ? 4'd8 : 4'd9) || sram_din0 !== (exp_fill ? fill_data : 24'h0)) begin
        bad++;
        $display("FAIL rr_tie k=%0d got f=%b i=%b a=%0d d=%h want f=%b i=%b",
                 k, fill_ready, inv_ready, sram_addr0, sram_din0, exp_fill, !exp_fill);
      end
      step();
    end
    model[8] = 24'h800102; model[9] = '0;
    clr();
    push_lkp(4'd3, model[3]); step();
    push_lkp(4'd8, model[8]); step();
    push_lkp(4'd9, model[9]); step();
    push_lkp(4'd6, model[6]); step();
    clr(); step(); step();
  endtask

  task automatic test_later_write();
    clr(); fill_valid = 1'b1; fill_idx = 4'd10; fill_data = 24'hC0AAAA;
    step(); clr();
    inv_valid = 1'b1; inv_idx = 4'd10; model[10] = '0;
    push_lkp(4'd10, model[10]);
    step(); clr();
    push_lkp(4'd10, model[10]);
    step(); clr();
    inv_valid = 1'b1; inv_idx = 4'd10;
    step(); clr();
    fill_valid = 1'b1; fill_idx = 4'd10; fill_data = 24'h80BBBB; model[10] = 24'h80BBBB;
    step(); clr(); step();
    push_lkp(4'd10, model[10]);
    step(); clr(); step(); step();
  endtask

  task automatic test_flush();
    clr(); flush_req = 1'b1;
    fill_valid = 1'b1; fill_idx = 4'd2; fill_data = 24'h812345;
    push_lkp(4'd5, model[5]); #1;
    total++;
    if (fill_ready !== 1'b0 || sram_csb0 !== 1'b1 || lkp_ready !== 1'b1 || flush_busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_prio got frdy=%b cs0=%b lrdy=%b busy=%b want 0 1 1 0",
               fill_ready, sram_csb0, lkp_ready, flush_busy);
    end
    step(); lkp_valid = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      #1;
      total++;
      if ({sram_csb0, sram_web0} !== 2'b00 || sram_addr0 !== IDX_W'(i) || sram_din0 !== '0 ||
          fill_ready !== 1'b0 || lkp_ready !== 1'b0 || flush_busy !== 1'b1 || flush_done !== 1'b0) begin
        bad++;
        $display("FAIL flush_sweep i=%0d got cs=%b we=%b a=%0d d=%h frdy=%b lrdy=%b busy=%b done=%b want a=%0d",
                 i, sram_csb0, sram_web0, sram_addr0, sram_din0, fill_ready, lkp_ready, flush_busy, flush_done, i);
      end
      step();
    end
    #1;
    total++;
    if (flush_done !== 1'b1 || flush_busy !== 1'b0 || fill_ready !== 1'b1 || sram_addr0 !== 4'd2) begin
      bad++;
      $display("FAIL flush_end got done=%b busy=%b frdy=%b a0=%0d want 1 0 1 2",
               flush_done, flush_busy, fill_ready, sram_addr0);
    end
    for (int i = 0; i < SETS; i++) model[i] = '0;
    model[2] = 24'h812345;
    flush_req = 1'b0;
    step(); clr(); #1;
    total++;
    if (flush_done !== 1'b0 || flush_busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_done_pulse got done=%b busy=%b want 0 0", flush_done, flush_busy);
    end
    for (int i = 0; i < SETS; i++) begin
      push_lkp(IDX_W'(i), model[i]);
      step();
    end
    clr(); step(); step();
  endtask

  task automatic test_reset_mid_flush();
    clr(); flush_req = 1'b1;
    step(); flush_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if (sram_addr0 !== IDX_W'(i) || flush_busy !== 1'b1) begin
        bad++;
        $display("FAIL flush_pre_rst i=%0d got a0=%0d busy=%b want %0d 1", i, sram_addr0, flush_busy, i);
      end
      if (i < 7) step();
    end
    rst = 1'b1; #1;
    total++;
    if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1) begin
      bad++;
      $display("FAIL rst_idle got cs0=%b we0=%b want 1 1", sram_csb0, sram_web0);
    end
    step(); rst = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      #1;
      total++;
      if (sram_addr0 !== IDX_W'(i) || sram_csb0 !== 1'b0 || init_done !== 1'b0 || flush_done !== 1'b0) begin
        bad++;
        $display("FAIL reinit i=%0d got a0=%0d cs0=%b idone=%b done=%b want %0d 0 0 0",
                 i, sram_addr0, sram_csb0, init_done, flush_done, i);
      end
      step();
    end
    #1;
    total++;
    if (init_done !== 1'b1 || flush_done !== 1'b0) begin
      bad++;
      $display("FAIL reinit_end got idone=%b done=%b want 1 0", init_done, flush_done);
    end
    for (int i = 0; i < SETS; i++) model[i] = '0;
    push_lkp(4'd2, model[2]); step();
    push_lkp(4'd15, model[15]); step();
    clr(); step(); step();
  endtask

  initial begin
    test_reset();
    test_fill_lookup();
    test_bypass();
    test_arbitration();
    test_later_write();
    test_flush();
    test_reset_mid_flush();
    step(); step();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
